// File: rtl/rob_commit_if.sv
// Dispatcher/CDB/regfile-facing signal bundle of the reorder buffer.
// The slave modport is the ROB side; the master modport is the environment side.
interface rob_commit_if #(
    parameter int ID_WIDTH = 4
);
    logic                alloc_en;
    logic [5:0]          alloc_rd;
    logic                alloc_is_branch;
    logic                alloc_is_store;
    logic [ID_WIDTH-1:0] alloc_id;
    logic                full;

    logic                cdb0_en;
    logic [ID_WIDTH-1:0] cdb0_id;
    logic [31:0]         cdb0_val;
    logic                cdb0_mispred;
    logic [31:0]         cdb0_pc;
    logic                cdb1_en;
    logic [ID_WIDTH-1:0] cdb1_id;
    logic [31:0]         cdb1_val;

    logic [ID_WIDTH-1:0] qry_j_id;
    logic [ID_WIDTH-1:0] qry_k_id;
    logic                qry_j_ready;
    logic                qry_k_ready;
    logic [31:0]         qry_j_val;
    logic [31:0]         qry_k_val;

    logic                enable_to_reg;
    logic [5:0]          rd_to_reg;
    logic [ID_WIDTH-1:0] q_to_reg;
    logic [31:0]         v_to_reg;
    logic                store_commit;
    logic [ID_WIDTH-1:0] store_commit_id;
    logic                mispredict;
    logic [31:0]         pc_to_fetch;

    modport slave (
        input  alloc_en, alloc_rd, alloc_is_branch, alloc_is_store,
        output alloc_id, full,
        input  cdb0_en, cdb0_id, cdb0_val, cdb0_mispred, cdb0_pc,
        input  cdb1_en, cdb1_id, cdb1_val,
        input  qry_j_id, qry_k_id,
        output qry_j_ready, qry_k_ready, qry_j_val, qry_k_val,
        output enable_to_reg, rd_to_reg, q_to_reg, v_to_reg,
        output store_commit, store_commit_id, mispredict, pc_to_fetch
    );

    modport master (
        output alloc_en, alloc_rd, alloc_is_branch, alloc_is_store,
        input  alloc_id, full,
        output cdb0_en, cdb0_id, cdb0_val, cdb0_mispred, cdb0_pc,
        output cdb1_en, cdb1_id, cdb1_val,
        output qry_j_id, qry_k_id,
        input  qry_j_ready, qry_k_ready, qry_j_val, qry_k_val,
        input  enable_to_reg, rd_to_reg, q_to_reg, v_to_reg,
        input  store_commit, store_commit_id, mispredict, pc_to_fetch
    );
endinterface

// File: rtl/rob_commit.sv
// In-order reorder buffer: allocates for dispatch, captures two CDBs, retires the
// head into the regfile / store path, and raises a one-cycle flush on mispredict.
module rob_commit #(
    parameter int ROB_SIZE = 16,
    parameter int ID_WIDTH = 4,
    parameter int REG_NONE = 32
) (
    input logic clk,
    input logic rst,
    input logic rdy,
    rob_commit_if.slave bus
);
    localparam int CW = ID_WIDTH + 1;
    localparam logic [CW-1:0]       CAP     = CW'(ROB_SIZE);
    localparam logic [ID_WIDTH-1:0] ID_ONE  = ID_WIDTH'(1);
    localparam logic [5:0]          RD_NONE = 6'(REG_NONE);

    logic [ROB_SIZE-1:0] busy;
    logic [ROB_SIZE-1:0] ready;
    logic [ROB_SIZE-1:0] is_branch;
    logic [ROB_SIZE-1:0] is_store;
    logic [ROB_SIZE-1:0] mispred;
    logic [5:0]          rd_q    [ROB_SIZE];
    logic [31:0]         value_q [ROB_SIZE];
    logic [31:0]         pc_q    [ROB_SIZE];

    logic [ID_WIDTH-1:0] head;
    logic [ID_WIDTH-1:0] tail;
    logic [CW-1:0]       count;

    logic                enable_r;
    logic [5:0]          rd_r;
    logic [ID_WIDTH-1:0] q_r;
    logic [31:0]         v_r;
    logic                store_r;
    logic [ID_WIDTH-1:0] store_id_r;
    logic                mispredict_r;
    logic [31:0]         pc_r;

    logic full;
    logic live;
    logic do_alloc;
    logic do_commit;
    logic do_flush;
    logic wb0;
    logic wb1;
    logic head_writes_reg;

    assign full      = (count == CAP);
    assign live      = rdy && !mispredict_r;
    assign do_alloc  = live && bus.alloc_en && !full;
    assign do_commit = live && (count != '0) && ready[head];
    assign do_flush  = do_commit && is_branch[head] && mispred[head];
    assign wb0       = live && bus.cdb0_en && busy[bus.cdb0_id];
    assign wb1       = live && bus.cdb1_en && busy[bus.cdb1_id];
    assign head_writes_reg = !is_store[head] && (rd_q[head] != '0) && (rd_q[head] != RD_NONE);

    // Control state and registered commit outputs; a flush overrides any
    // allocation or writeback landing on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy         <= '0;
            ready        <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            enable_r     <= 1'b0;
            rd_r         <= '0;
            q_r          <= '0;
            v_r          <= '0;
            store_r      <= 1'b0;
            store_id_r   <= '0;
            mispredict_r <= 1'b0;
            pc_r         <= '0;
        end else if (rdy) begin
            enable_r     <= do_commit && head_writes_reg;
            store_r      <= do_commit && is_store[head];
            mispredict_r <= do_flush;
            if (do_commit && head_writes_reg) begin
                rd_r <= rd_q[head];
                q_r  <= head;
                v_r  <= value_q[head];
            end
            if (do_commit && is_store[head]) begin
                store_id_r <= head;
            end
            if (do_flush) begin
                pc_r  <= pc_q[head];
                busy  <= '0;
                ready <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_commit) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= head + ID_ONE;
                end
                if (do_alloc) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                    tail        <= tail + ID_ONE;
                end
                if (wb1) ready[bus.cdb1_id] <= 1'b1;
                if (wb0) ready[bus.cdb0_id] <= 1'b1;
                count <= count + CW'(do_alloc) - CW'(do_commit);
            end
        end
    end

    // Payload storage; CDB0 is written last so it wins a same-tag collision.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            rd_q[tail]      <= bus.alloc_rd;
            is_branch[tail] <= bus.alloc_is_branch;
            is_store[tail]  <= bus.alloc_is_store;
            mispred[tail]   <= 1'b0;
        end
        if (wb1) begin
            value_q[bus.cdb1_id] <= bus.cdb1_val;
            mispred[bus.cdb1_id] <= 1'b0;
        end
        if (wb0) begin
            value_q[bus.cdb0_id] <= bus.cdb0_val;
            mispred[bus.cdb0_id] <= bus.cdb0_mispred;
            pc_q[bus.cdb0_id]    <= bus.cdb0_pc;
        end
    end

    always_comb begin
        bus.qry_j_ready = 1'b0;
        bus.qry_j_val   = '0;
        if (!mispredict_r) begin
            if (bus.cdb0_en && bus.cdb0_id == bus.qry_j_id) begin
                bus.qry_j_ready = 1'b1;
                bus.qry_j_val   = bus.cdb0_val;
            end else if (bus.cdb1_en && bus.cdb1_id == bus.qry_j_id) begin
                bus.qry_j_ready = 1'b1;
                bus.qry_j_val   = bus.cdb1_val;
            end else if (busy[bus.qry_j_id] && ready[bus.qry_j_id]) begin
                bus.qry_j_ready = 1'b1;
                bus.qry_j_val   = value_q[bus.qry_j_id];
            end
        end
    end

    always_comb begin
        bus.qry_k_ready = 1'b0;
        bus.qry_k_val   = '0;
        if (!mispredict_r) begin
            if (bus.cdb0_en && bus.cdb0_id == bus.qry_k_id) begin
                bus.qry_k_ready = 1'b1;
                bus.qry_k_val   = bus.cdb0_val;
            end else if (bus.cdb1_en && bus.cdb1_id == bus.qry_k_id) begin
                bus.qry_k_ready = 1'b1;
                bus.qry_k_val   = bus.cdb1_val;
            end else if (busy[bus.qry_k_id] && ready[bus.qry_k_id]) begin
                bus.qry_k_ready = 1'b1;
                bus.qry_k_val   = value_q[bus.qry_k_id];
            end
        end
    end

    assign bus.alloc_id        = tail;
    assign bus.full            = full;
    assign bus.enable_to_reg   = enable_r;
    assign bus.rd_to_reg       = rd_r;
    assign bus.q_to_reg        = q_r;
    assign bus.v_to_reg        = v_r;
    assign bus.store_commit    = store_r;
    assign bus.store_commit_id = store_id_r;
    assign bus.mispredict      = mispredict_r;
    assign bus.pc_to_fetch     = pc_r;
endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: a per-cycle vector table for the basic commit
// flow, plus hand sequences for full/wrap, mispredict flush, CDB collision and stores.
module tb_rob_commit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;

    rob_commit_if #(.ID_WIDTH(4)) bus ();

    rob_commit #(.ROB_SIZE(16), .ID_WIDTH(4), .REG_NONE(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        alloc_en;
        logic [5:0]  alloc_rd;
        logic        c0_en;
        logic [3:0]  c0_id;
        logic [31:0] c0_val;
        logic        c1_en;
        logic [3:0]  c1_id;
        logic [31:0] c1_val;
        logic [3:0]  qid;
        logic        exp_qrdy;
        logic [31:0] exp_qval;
        logic        exp_en;
        logic [5:0]  exp_rd;
        logic [3:0]  exp_q;
        logic [31:0] exp_v;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.alloc_en = 0; bus.alloc_rd = 0; bus.alloc_is_branch = 0; bus.alloc_is_store = 0;
        bus.cdb0_en = 0; bus.cdb0_id = 0; bus.cdb0_val = 0; bus.cdb0_mispred = 0; bus.cdb0_pc = 0;
        bus.cdb1_en = 0; bus.cdb1_id = 0; bus.cdb1_val = 0;
        bus.qry_j_id = 4'd15; bus.qry_k_id = 4'd15;
    endtask

    task automatic do_reset();
        idle_inputs();
        rdy = 1;
        rst = 0;
        tick();
        tick();
        rst = 1;
    endtask

    task automatic alloc(input logic [5:0] rd, input logic br, input logic st);
        bus.alloc_en = 1; bus.alloc_rd = rd; bus.alloc_is_branch = br; bus.alloc_is_store = st;
        tick();
        bus.alloc_en = 0; bus.alloc_is_branch = 0; bus.alloc_is_store = 0;
    endtask

    initial begin
        // alloc, rd, c0_en,id,val, c1_en,id,val, qid, qrdy, qval, en, rd, q, v
        vecs.push_back('{1, 6'd5,  0, 4'd0, 32'h0,    0, 4'd0, 32'h0,  4'd0,  0, 32'h0,    0, 6'd0,  4'd0, 32'h0});
        vecs.push_back('{0, 6'd0,  1, 4'd0, 32'h1234, 0, 4'd0, 32'h0,  4'd0,  1, 32'h1234, 0, 6'd0,  4'd0, 32'h0});
        vecs.push_back('{0, 6'd0,  0, 4'd0, 32'h0,    0, 4'd0, 32'h0,  4'd15, 0, 32'h0,    1, 6'd5,  4'd0, 32'h1234});
        vecs.push_back('{0, 6'd0,  0, 4'd0, 32'h0,    0, 4'd0, 32'h0,  4'd15, 0, 32'h0,    0, 6'd0,  4'd0, 32'h0});
        vecs.push_back('{1, 6'd6,  0, 4'd0, 32'h0,    0, 4'd0, 32'h0,  4'd15, 0, 32'h0,    0, 6'd0,  4'd0, 32'h0});
        vecs.push_back('{1, 6'd7,  0, 4'd0, 32'h0,    0, 4'd0, 32'h0,  4'd15, 0, 32'h0,    0, 6'd0,  4'd0, 32'h0});
        vecs.push_back('{1, 6'd8,  0, 4'd0, 32'h0,    0, 4'd0, 32'h0,  4'd15, 0, 32'h0,    0, 6'd0,  4'd0, 32'h0});
        vecs.push_back('{0, 6'd0,  1, 4'd3, 32'h33,   0, 4'd0, 32'h0,  4'd1,  0, 32'h0,    0, 6'd0,  4'd0, 32'h0});
        vecs.push_back('{0, 6'd0,  0, 4'd0, 32'h0,    1, 4'd2, 32'h22, 4'd2,  1, 32'h22,   0, 6'd0,  4'd0, 32'h0});
        vecs.push_back('{0, 6'd0,  1, 4'd1, 32'h11,   0, 4'd0, 32'h0,  4'd3,  1, 32'h33,   0, 6'd0,  4'd0, 32'h0});
        vecs.push_back('{0, 6'd0,  0, 4'd0, 32'h0,    0, 4'd0, 32'h0,  4'd15, 0, 32'h0,    1, 6'd6,  4'd1, 32'h11});
        vecs.push_back('{1, 6'd10, 0, 4'd0, 32'h0,    0, 4'd0, 32'h0,  4'd15, 0, 32'h0,    1, 6'd7,  4'd2, 32'h22});
        vecs.push_back('{0, 6'd0,  0, 4'd0, 32'h0,    0, 4'd0, 32'h0,  4'd15, 0, 32'h0,    1, 6'd8,  4'd3, 32'h33});
        vecs.push_back('{0, 6'd0,  0, 4'd0, 32'h0,    0, 4'd0, 32'h0,  4'd15, 0, 32'h0,    0, 6'd0,  4'd0, 32'h0});
        vecs.push_back('{0, 6'd0,  0, 4'd0, 32'h0,    1, 4'd4, 32'h44, 4'd15, 0, 32'h0,    0, 6'd0,  4'd0, 32'h0});
        vecs.push_back('{0, 6'd0,  0, 4'd0, 32'h0,    0, 4'd0, 32'h0,  4'd15, 0, 32'h0,    1, 6'd10, 4'd4, 32'h44});
        vecs.push_back('{1, 6'd32, 0, 4'd0, 32'h0,    0, 4'd0, 32'h0,  4'd15, 0, 32'h0,    0, 6'd0,  4'd0, 32'h0});
        vecs.push_back('{0, 6'd0,  1, 4'd5, 32'h55,   0, 4'd0, 32'h0,  4'd15, 0, 32'h0,    0, 6'd0,  4'd0, 32'h0});
        vecs.push_back('{0, 6'd0,  0, 4'd0, 32'h0,    0, 4'd0, 32'h0,  4'd15, 0, 32'h0,    0, 6'd0,  4'd0, 32'h0});
        vecs.push_back('{1, 6'd0,  0, 4'd0, 32'h0,    0, 4'd0, 32'h0,  4'd5,  0, 32'h0,    0, 6'd0,  4'd0, 32'h0});
        vecs.push_back('{0, 6'd0,  1, 4'd6, 32'h66,   0, 4'd0, 32'h0,  4'd15, 0, 32'h0,    0, 6'd0,  4'd0, 32'h0});
        vecs.push_back('{0, 6'd0,  0, 4'd0, 32'h0,    0, 4'd0, 32'h0,  4'd15, 0, 32'h0,    0, 6'd0,  4'd0, 32'h0});
        vecs.push_back('{1, 6'd31, 0, 4'd0, 32'h0,    0, 4'd0, 32'h0,  4'd15, 0, 32'h0,    0, 6'd0,  4'd0, 32'h0});
        vecs.push_back('{0, 6'd0,  0, 4'd0, 32'h0,    1, 4'd7, 32'h77, 4'd7,  1, 32'h77,   0, 6'd0,  4'd0, 32'h0});
        vecs.push_back('{0, 6'd0,  0, 4'd0, 32'h0,    0, 4'd0, 32'h0,  4'd15, 0, 32'h0,    1, 6'd31, 4'd7, 32'h77});

        idle_inputs();
        @(negedge clk);
        do_reset();

        // Reset state
        chk("rst_enable", bus.enable_to_reg, 0);
        chk("rst_store", bus.store_commit, 0);
        chk("rst_mispredict", bus.mispredict, 0);
        chk("rst_pc", bus.pc_to_fetch, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_alloc_id", bus.alloc_id, 0);

        // Table: basic commit latency, in-order retire, CDB forwarding, rd filtering
        for (int i = 0; i < vecs.size(); i++) begin
            bus.alloc_en = vecs[i].alloc_en; bus.alloc_rd = vecs[i].alloc_rd;
            bus.cdb0_en = vecs[i].c0_en; bus.cdb0_id = vecs[i].c0_id; bus.cdb0_val = vecs[i].c0_val;
            bus.cdb1_en = vecs[i].c1_en; bus.cdb1_id = vecs[i].c1_id; bus.cdb1_val = vecs[i].c1_val;
            bus.qry_j_id = vecs[i].qid;
            #1;
            chk($sformatf("v%0d_qry_ready", i), bus.qry_j_ready, vecs[i].exp_qrdy);
            chk($sformatf("v%0d_qry_val", i), bus.qry_j_val, vecs[i].exp_qval);
            tick();
            chk($sformatf("v%0d_enable", i), bus.enable_to_reg, vecs[i].exp_en);
            if (vecs[i].exp_en) begin
                chk($sformatf("v%0d_rd", i), bus.rd_to_reg, vecs[i].exp_rd);
                chk($sformatf("v%0d_q", i), bus.q_to_reg, vecs[i].exp_q);
                chk($sformatf("v%0d_v", i), bus.v_to_reg, vecs[i].exp_v);
            end
        end
        idle_inputs();

        // Full, ignored 17th alloc, wrap of tail
        do_reset();
        bus.alloc_en = 1; bus.alloc_rd = 6'd3;
        for (int i = 0; i < 16; i++) tick();
        chk("full_after16", bus.full, 1);
        chk("alloc_id_after16", bus.alloc_id, 0);
        tick();
        chk("full_after17", bus.full, 1);
        chk("alloc_id_after17", bus.alloc_id, 0);
        bus.alloc_en = 0;
        bus.cdb0_en = 1; bus.cdb0_id = 0; bus.cdb0_val = 32'h100;
        tick();
        bus.cdb0_en = 0;
        chk("wrap_no_early_commit", bus.enable_to_reg, 0);
        bus.alloc_en = 1;
        tick();
        chk("wrap_commit0_en", bus.enable_to_reg, 1);
        chk("wrap_commit0_q", bus.q_to_reg, 0);
        chk("wrap_full_after_pop", bus.full, 0);
        chk("wrap_alloc_id_after_pop", bus.alloc_id, 0);
        tick();
        chk("wrap_full_refill", bus.full, 1);
        chk("wrap_tail_1", bus.alloc_id, 1);
        bus.alloc_en = 0;
        bus.cdb0_en = 1; bus.cdb0_id = 1; bus.cdb0_val = 32'h101;
        bus.cdb1_en = 1; bus.cdb1_id = 2; bus.cdb1_val = 32'h102;
        tick();
        idle_inputs();
        tick();
        chk("wrap_commit1_q", bus.q_to_reg, 1);
        chk("wrap_full_15", bus.full, 0);
        bus.alloc_en = 1; bus.alloc_rd = 6'd3;
        tick();
        chk("same_edge_commit_q", bus.q_to_reg, 2);
        chk("same_edge_en", bus.enable_to_reg, 1);
        chk("same_edge_full", bus.full, 0);
        chk("same_edge_tail", bus.alloc_id, 2);
        tick();
        chk("same_edge_count_kept", bus.full, 1);
        chk("same_edge_tail3", bus.alloc_id, 3);
        idle_inputs();

        // Branch mispredict flush
        do_reset();
        for (int i = 0; i < 8; i++) alloc((i == 3) ? 6'd1 : 6'(i + 10), (i == 3), 0);
        for (int i = 0; i < 4; i++) begin
            bus.cdb0_en = (i < 3); bus.cdb0_id = 4'(i); bus.cdb0_val = 32'(i);
            bus.cdb1_en = 1; bus.cdb1_id = 4'(i + 4); bus.cdb1_val = 32'(i + 4);
            tick();
        end
        idle_inputs();
        bus.cdb0_en = 1; bus.cdb0_id = 3; bus.cdb0_val = 32'h3c;
        bus.cdb0_mispred = 1; bus.cdb0_pc = 32'h80;
        tick();
        idle_inputs();
        chk("br_no_early_flush", bus.mispredict, 0);
        tick();
        chk("br_mispredict", bus.mispredict, 1);
        chk("br_pc", bus.pc_to_fetch, 32'h80);
        chk("br_link_en", bus.enable_to_reg, 1);
        chk("br_link_rd", bus.rd_to_reg, 1);
        chk("br_link_q", bus.q_to_reg, 3);
        chk("br_link_v", bus.v_to_reg, 32'h3c);
        bus.alloc_en = 1; bus.alloc_rd = 6'd9;
        bus.cdb1_en = 1; bus.cdb1_id = 4; bus.cdb1_val = 32'h44;
        bus.qry_j_id = 4;
        #1;
        chk("br_qry_blocked_ready", bus.qry_j_ready, 0);
        chk("br_qry_blocked_val", bus.qry_j_val, 0);
        tick();
        idle_inputs();
        chk("br_pulse_end", bus.mispredict, 0);
        chk("br_full_cleared", bus.full, 0);
        chk("br_alloc_id_0", bus.alloc_id, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("br_young_%0d_no_commit", i), bus.enable_to_reg, 0);
        end

        // Both CDBs on the same tag: CDB0 wins
        do_reset();
        alloc(6'd4, 0, 0);
        alloc(6'd5, 0, 0);
        alloc(6'd6, 0, 0);
        bus.cdb0_en = 1; bus.cdb0_id = 0; bus.cdb0_val = 32'h1;
        bus.cdb1_en = 1; bus.cdb1_id = 1; bus.cdb1_val = 32'h2;
        bus.qry_k_id = 1;
        #1;
        chk("cdb1_fwd_ready", bus.qry_k_ready, 1);
        chk("cdb1_fwd_val", bus.qry_k_val, 32'h2);
        tick();
        bus.cdb0_en = 1; bus.cdb0_id = 2; bus.cdb0_val = 32'hA;
        bus.cdb1_en = 1; bus.cdb1_id = 2; bus.cdb1_val = 32'hB;
        bus.qry_j_id = 2; bus.qry_k_id = 9;
        #1;
        chk("collide_qry_ready", bus.qry_j_ready, 1);
        chk("collide_qry_val", bus.qry_j_val, 32'hA);
        chk("idle_tag_ready", bus.qry_k_ready, 0);
        tick();
        idle_inputs();
        tick();
        tick();
        chk("collide_commit_q", bus.q_to_reg, 2);
        chk("collide_commit_v", bus.v_to_reg, 32'hA);

        // Store commit and rdy stall
        do_reset();
        alloc(6'd7, 0, 1);
        alloc(6'd7, 0, 1);
        bus.cdb0_en = 1; bus.cdb0_id = 0; bus.cdb0_val = 32'h5;
        bus.cdb1_en = 1; bus.cdb1_id = 1; bus.cdb1_val = 32'h6;
        tick();
        idle_inputs();
        tick();
        chk("st0_commit", bus.store_commit, 1);
        chk("st0_id", bus.store_commit_id, 0);
        chk("st0_no_reg", bus.enable_to_reg, 0);
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d_store_hold", i), bus.store_commit, 1);
            chk($sformatf("stall%0d_id_hold", i), bus.store_commit_id, 0);
        end
        rdy = 1;
        tick();
        chk("st1_commit", bus.store_commit, 1);
        chk("st1_id", bus.store_commit_id, 1);
        tick();
        chk("st_pulse_end", bus.store_commit, 0);

        // Asynchronous reset with a commit pulse in flight
        alloc(6'd9, 0, 0);
        bus.cdb0_en = 1; bus.cdb0_id = 2; bus.cdb0_val = 32'h99;
        tick();
        idle_inputs();
        tick();
        chk("pre_rst_en", bus.enable_to_reg, 1);
        chk("pre_rst_q", bus.q_to_reg, 2);
        rst = 0;
        #1;
        chk("async_rst_en", bus.enable_to_reg, 0);
        chk("async_rst_v", bus.v_to_reg, 0);
        chk("async_rst_alloc_id", bus.alloc_id, 0);
        tick();
        rst = 1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
